servo_pulse_decoder: RTL and testbench



---
 rtl/servo_pkg.sv | 16 +
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/servo_pulse_decoder.sv | 143 ++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing constants and decoder state encoding.
// Imported by the servo PWM decoder and its sibling generator.
package servo_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int SERVO_PERIOD_CYCLES = 1_000_000;
  localparam int MIN_CYCLES          = 30_000;
  localparam int STEP_CYCLES         = 392;

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    MEASURE
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus delay flop.
// Produces one-cycle rise/fall pulses on the synchronized level.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM high-time decoder: width -> 8-bit position code,
// with glitch/overlong pulse rejection and loss-of-signal flag.
module servo_pulse_decoder #(
  parameter int MIN_CYCLES       = servo_pkg::MIN_CYCLES,
  parameter int STEP_CYCLES      = servo_pkg::STEP_CYCLES,
  parameter int GLITCH_CYCLES    = 25_000,
  parameter int MAX_PULSE_CYCLES = 150_000,
  parameter int TIMEOUT_CYCLES   = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] position,
  output logic       valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  import servo_pkg::*;

  localparam int WW = $clog2(MAX_PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES);

  localparam logic [WW-1:0] L_MIN    = WW'(MIN_CYCLES);
  localparam logic [WW-1:0] L_GLITCH = WW'(GLITCH_CYCLES);
  localparam logic [WW-1:0] L_MAX    = WW'(MAX_PULSE_CYCLES);
  localparam logic [TW-1:0] L_TO     = TW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] L_SLAST  = SW'(STEP_CYCLES - 1);

  logic w_pwm_s;
  logic w_rise;
  logic w_fall;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [WW-1:0] r_width;
  logic [WW-1:0] w_width_nxt;
  logic [WW-1:0] w_wcur;
  logic [SW-1:0] r_step;
  logic [SW-1:0] w_step_nxt;
  logic [7:0]    r_acc;
  logic [7:0]    w_acc_nxt;
  logic [7:0]    r_pos;
  logic [7:0]    w_pos_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic [TW-1:0] r_to;
  logic [1:0]    r_settle;

  pwm_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (pwm_in),
    .o_sync  (w_pwm_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_wcur = (r_width == L_MAX) ? r_width : r_width + WW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_width_nxt = r_width;
    w_step_nxt  = r_step;
    w_acc_nxt   = r_acc;
    w_pos_nxt   = r_pos;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      // Synchronizer reads 0 right after reset; wait until it tracks the pin
      ARM: begin
        if (r_settle == 2'd3 && !w_pwm_s) w_state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_width_nxt = WW'(1);
          w_step_nxt  = '0;
          w_acc_nxt   = '0;
        end
      end
      MEASURE: begin
        if (w_fall) begin
          w_state_nxt = WAIT_RISE;
          if (r_width < L_GLITCH) begin
            w_err_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_pos_nxt   = (r_width < L_MIN) ? 8'd0 : r_acc;
          end
        end else if (w_wcur == L_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ARM;
        end else begin
          w_width_nxt = w_wcur;
          if (w_wcur > L_MIN) begin
            if (r_step == L_SLAST) begin
              w_step_nxt = '0;
              if (r_acc != 8'hFF) w_acc_nxt = r_acc + 8'd1;
            end else begin
              w_step_nxt = r_step + SW'(1);
            end
          end
        end
      end
      default: w_state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARM;
      r_width  <= '0;
      r_step   <= '0;
      r_acc    <= '0;
      r_pos    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_to     <= '0;
      r_settle <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_width <= w_width_nxt;
      r_step  <= w_step_nxt;
      r_acc   <= w_acc_nxt;
      r_pos   <= w_pos_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (w_rise)            r_to <= '0;
      else if (r_to != L_TO) r_to <= r_to + TW'(1);
    end
  end

  assign position    = r_pos;
  assign valid       = r_valid;
  assign pulse_err   = r_err;
  assign signal_lost = (r_to == L_TO);

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with scaled-down timing
// (MIN 600, STEP 8, GLITCH 500, MAX 3000, TIMEOUT 25000).
module tb_servo_pulse_decoder;

  localparam int MINC = 600;
  localparam int STEP = 8;
  localparam int GLT  = 500;
  localparam int MAXC = 3000;
  localparam int TOC  = 25000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] position;
  logic       valid;
  logic       pulse_err;
  logic       signal_lost;

  typedef struct {
    bit         err;
    logic [7:0] pos;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t_rise = 0;

  servo_pulse_decoder #(
    .MIN_CYCLES       (MINC),
    .STEP_CYCLES      (STEP),
    .GLITCH_CYCLES    (GLT),
    .MAX_PULSE_CYCLES (MAXC),
    .TIMEOUT_CYCLES   (TOC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .position    (position),
    .valid       (valid),
    .pulse_err   (pulse_err),
    .signal_lost (signal_lost)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && (valid || pulse_err)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b pos=%0d cyc=%0d",
                 valid, pulse_err, position, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((valid && pulse_err) || pulse_err !== e.err ||
            valid !== !e.err || position !== e.pos || cyc !== e.cyc) begin
          failures++;
          $display("FAIL strobe: got valid=%0b err=%0b pos=%0d cyc=%0d, want err=%0b pos=%0d cyc=%0d",
                   valid, pulse_err, position, cyc, e.err, e.pos, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic pulse(input int w, input bit err, input int pos, input int gap);
    @(negedge clk);
    sb.push_back('{err, 8'(pos), cyc + w + 3});
    pwm_in = 1'b1;
    t_rise = cyc;
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int q;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_position", position, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", pulse_err, 0);
    chk("rst_lost", signal_lost, 0);
    repeat (10) @(negedge clk);

    pulse(600, 0, 0, 200);
    pulse(1400, 0, 100, 200);
    pulse(1407, 0, 100, 200);
    pulse(1408, 0, 101, 200);
    pulse(2700, 0, 255, 200);
    pulse(2900, 0, 255, 200);
    pulse(400, 1, 255, 200);
    pulse(540, 0, 0, 200);
    pulse(1200, 0, 75, 200);

    // held high past the maximum: error when the width hits MAXC
    @(negedge clk);
    sb.push_back('{1'b1, 8'd75, cyc + MAXC + 2});
    pwm_in = 1'b1;
    repeat (3200) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    chk("max_hold_pos", position, 75);

    pulse(1000, 0, 50, 200);

    // loss of signal relative to the last pin rise
    while (cyc < t_rise + TOC + 2) @(negedge clk);
    chk("lost_before", signal_lost, 0);
    @(negedge clk);
    chk("lost_at", signal_lost, 1);
    chk("lost_pos_held", position, 50);
    repeat (100) @(negedge clk);
    chk("lost_stays", signal_lost, 1);

    @(negedge clk);
    sb.push_back('{1'b0, 8'd100, cyc + 1400 + 3});
    pwm_in = 1'b1;
    q = cyc;
    repeat (2) @(negedge clk);
    chk("lost_until_rise", signal_lost, 1);
    @(negedge clk);
    chk("lost_cleared", signal_lost, 0);
    repeat (1400 - 3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    chk("cleared_cycle_base", cyc - q > 1400 ? 1 : 0, 1);

    // reset in the middle of an 800-cycle pulse: no strobe expected
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (400) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pos", position, 0);
    chk("midrst_lost", signal_lost, 0);
    repeat (394) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_no_strobe", sb.size(), 0);

    pulse(1408, 0, 101, 200);

    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
